// File: rtl/axis_hdr_pkg.sv
// Shared types and keep/count helpers for the AXI-Stream header insert/strip blocks.
// Helpers work on a wide keep vector; callers slice the low DATA_BYTE_WD bits.
package axis_hdr_pkg;

  localparam int unsigned MAX_BYTES = 128;

  typedef logic [MAX_BYTES-1:0] keep_t;
  typedef logic [7:0]           cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } state_t;

  function automatic cnt_t keep_to_cnt(input keep_t keep);
    cnt_t cnt;
    cnt = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      cnt = cnt + cnt_t'(keep[i]);
    end
    return cnt;
  endfunction

  function automatic keep_t cnt_to_keep_lsb(input cnt_t cnt);
    keep_t m;
    m = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      m[i] = (cnt_t'(i) < cnt);
    end
    return m;
  endfunction

  // Top cnt bytes of a width-byte word; cnt saturates at width.
  function automatic keep_t cnt_to_keep_msb(input cnt_t cnt, input cnt_t width);
    keep_t m;
    cnt_t  c;
    c = (cnt > width) ? width : cnt;
    m = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      m[i] = (cnt_t'(i) < width) && (cnt_t'(i) >= (width - c));
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_byte_merge.sv
// Combinational byte merge: residue's low n bytes followed by the top bytes of data_in,
// plus the low n bytes of data_in carried forward as the next residue.
module axis_byte_merge #(
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned CNT_WD  = 3
) (
  input  logic [DATA_WD-1:0] residue,
  input  logic [DATA_WD-1:0] data_in,
  input  logic [CNT_WD-1:0]  n,
  output logic [DATA_WD-1:0] merged,
  output logic [DATA_WD-1:0] next_residue
);

  localparam logic [DATA_WD-1:0] ONES = '1;

  int unsigned n_bits;

  // Shifts by the full word width yield zero, which covers n=0 and n=W.
  always_comb begin
    n_bits       = 8 * 32'(n);
    merged       = (residue << (DATA_WD - n_bits)) | (data_in >> n_bits);
    next_residue = data_in & ~(ONES << n_bits);
  end

endmodule

// File: rtl/axis_hdr_insert_gen.sv
// AXI-Stream header inserter: prepends 0..W header bytes to each packet and re-packs
// the stream into dense MSB-aligned beats, with a flush beat when the tail overflows.
module axis_hdr_insert_gen
  import axis_hdr_pkg::*;
#(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int unsigned PKT_CNT_WD   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_in,
  input  logic [DATA_WD-1:0]        data_in,
  input  logic [DATA_BYTE_WD-1:0]   keep_in,
  input  logic                      last_in,
  output logic                      ready_in,
  output logic                      valid_out,
  output logic [DATA_WD-1:0]        data_out,
  output logic [DATA_BYTE_WD-1:0]   keep_out,
  output logic                      last_out,
  input  logic                      ready_out,
  input  logic                      valid_insert,
  input  logic [DATA_WD-1:0]        data_insert,
  input  logic [DATA_BYTE_WD-1:0]   keep_insert,
  input  logic [BYTE_CNT_WD:0]      byte_insert_cnt,
  output logic                      ready_insert,
  output logic [PKT_CNT_WD-1:0]     pkt_cnt,
  output logic                      err_keep
);

  localparam int unsigned NW    = BYTE_CNT_WD + 1;
  localparam cnt_t        W_CNT = cnt_t'(DATA_BYTE_WD);

  state_t                    state_q, state_d;
  logic [NW-1:0]             n_q, n_d;
  logic [DATA_WD-1:0]        res_q, res_d;
  logic [DATA_BYTE_WD-1:0]   fkeep_q, fkeep_d;
  logic                      valid_q, valid_d;
  logic [DATA_WD-1:0]        data_q, data_d;
  logic [DATA_BYTE_WD-1:0]   keep_q, keep_d;
  logic                      last_q, last_d;
  logic [PKT_CNT_WD-1:0]     pkt_q, pkt_d;
  logic                      err_q, err_d;

  logic [DATA_WD-1:0] merge_din, merged, next_res;
  cnt_t               k_cnt, tot, hdr_cnt, hdr_pop;
  keep_t              m_contig, m_last, m_flush, m_hdr;
  logic [NW-1:0]      hdr_n;
  logic               hdr_bad, keep_bad, o_free;
  logic               unused_bits;

  function automatic logic [DATA_WD-1:0] keep_bits(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] b;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
      b[8*i +: 8] = {8{k[i]}};
    end
    return b;
  endfunction

  // In FLUSH the merge runs on a zero word, shifting the residue to the top.
  assign merge_din = (state_q == FLUSH) ? '0 : data_in;

  axis_byte_merge #(
    .DATA_WD (DATA_WD),
    .CNT_WD  (NW)
  ) u_merge (
    .residue      (res_q),
    .data_in      (merge_din),
    .n            (n_q),
    .merged       (merged),
    .next_residue (next_res)
  );

  always_comb begin
    k_cnt    = keep_to_cnt(keep_t'(keep_in));
    tot      = cnt_t'(n_q) + k_cnt;
    m_contig = cnt_to_keep_msb(k_cnt, W_CNT);
    m_last   = cnt_to_keep_msb(tot, W_CNT);
    m_flush  = cnt_to_keep_msb(tot - W_CNT, W_CNT);
    hdr_cnt  = cnt_t'(byte_insert_cnt);
    hdr_pop  = keep_to_cnt(keep_t'(keep_insert));
    hdr_bad  = (hdr_cnt > W_CNT) || (hdr_pop != hdr_cnt);
    hdr_n    = (hdr_cnt > W_CNT) ? NW'(DATA_BYTE_WD) : byte_insert_cnt;
    m_hdr    = cnt_to_keep_lsb(cnt_t'(hdr_n));
    keep_bad = (m_contig[DATA_BYTE_WD-1:0] != keep_in) || (k_cnt == '0) ||
               (!last_in && (keep_in != '1));
  end

  assign unused_bits = ^{m_contig[MAX_BYTES-1:DATA_BYTE_WD], m_last[MAX_BYTES-1:DATA_BYTE_WD],
                         m_flush[MAX_BYTES-1:DATA_BYTE_WD], m_hdr[MAX_BYTES-1:DATA_BYTE_WD]};

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    res_d        = res_q;
    fkeep_d      = fkeep_q;
    valid_d      = valid_q;
    data_d       = data_q;
    keep_d       = keep_q;
    last_d       = last_q;
    pkt_d        = pkt_q;
    err_d        = err_q;
    o_free       = !valid_q || ready_out;
    ready_in     = (state_q == STREAM) && o_free;
    ready_insert = (state_q == IDLE);
    if (o_free) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_insert) begin
          n_d     = hdr_n;
          res_d   = data_insert & keep_bits(m_hdr[DATA_BYTE_WD-1:0]);
          err_d   = err_q | hdr_bad;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (valid_in && o_free) begin
          valid_d = 1'b1;
          res_d   = next_res;
          err_d   = err_q | keep_bad;
          data_d  = merged;
          keep_d  = '1;
          last_d  = 1'b0;
          if (last_in && (tot <= W_CNT)) begin
            data_d  = merged & keep_bits(m_last[DATA_BYTE_WD-1:0]);
            keep_d  = m_last[DATA_BYTE_WD-1:0];
            last_d  = 1'b1;
            pkt_d   = pkt_q + PKT_CNT_WD'(1);
            state_d = IDLE;
          end else if (last_in) begin
            fkeep_d = m_flush[DATA_BYTE_WD-1:0];
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (o_free) begin
          valid_d = 1'b1;
          data_d  = merged & keep_bits(fkeep_q);
          keep_d  = fkeep_q;
          last_d  = 1'b1;
          pkt_d   = pkt_q + PKT_CNT_WD'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      res_q   <= '0;
      fkeep_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      pkt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      res_q   <= res_d;
      fkeep_q <= fkeep_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign keep_out  = keep_q;
  assign last_out  = last_q;
  assign pkt_cnt   = pkt_q;
  assign err_keep  = err_q;

endmodule

// File: tb/tb_axis_hdr_insert_gen.sv
// Scoreboard bench for axis_hdr_insert_gen (W=4 bytes): a byte-list reference model
// packs header+payload into expected beats; a negedge monitor pops and compares.
module tb_axis_hdr_insert_gen;

  logic        clk;
  logic        rst_n;
  logic        valid_in, last_in, ready_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        valid_out, last_out, ready_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        valid_insert, ready_insert;
  logic [31:0] data_insert;
  logic [3:0]  keep_insert;
  logic [2:0]  byte_insert_cnt;
  logic [15:0] pkt_cnt;
  logic        err_keep;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  beat_t e;
  int    checks   = 0;
  int    failures = 0;
  int    pkt_exp  = 0;
  int    bp_mode  = 0;

  logic [31:0] h_d;
  logic [3:0]  h_k;
  logic        h_l;
  bit          held = 0;

  axis_hdr_insert_gen #(.DATA_WD(32), .PKT_CNT_WD(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
    .pkt_cnt(pkt_cnt), .err_keep(err_keep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: the packet is just a byte sequence, cut into 4-byte MSB-first beats.
  task automatic model_pkt(input int n, input logic [31:0] hdr, input logic [31:0] dat[$],
                           input int lastcnt);
    logic [7:0] bytes[$];
    beat_t      b;
    int         cnt;
    for (int i = n - 1; i >= 0; i--) bytes.push_back(hdr[8*i +: 8]);
    for (int j = 0; j < dat.size(); j++) begin
      cnt = (j == dat.size() - 1) ? lastcnt : 4;
      for (int k = 0; k < cnt; k++) bytes.push_back(dat[j][31-8*k -: 8]);
    end
    for (int p = 0; p < bytes.size(); p += 4) begin
      b = '0;
      for (int k = 0; k < 4; k++) begin
        if (p + k < bytes.size()) begin
          b.d[31-8*k -: 8] = bytes[p+k];
          b.k[3-k]         = 1'b1;
        end
      end
      b.l = (p + 4 >= bytes.size());
      exp_q.push_back(b);
    end
    pkt_exp++;
  endtask

  initial begin
    ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1:       ready_out = ($urandom_range(0, 3) != 0);
        2:       ready_out = 1'b0;
        default: ready_out = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 0;
    end else begin
      if (valid_out && !ready_out) begin
        chk("stall_ready_in", ready_in, 0);
        if (held) chk("stall_hold", {data_out, keep_out, last_out}, {h_d, h_k, h_l});
        held = 1;
        h_d  = data_out;
        h_k  = keep_out;
        h_l  = last_out;
      end else begin
        held = 0;
      end
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h required=none", data_out);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", data_out, e.d);
          chk("beat_keep", keep_out, e.k);
          chk("beat_last", last_out, e.l);
        end
      end
    end
  end

  task automatic check_reset();
    chk("rst_valid_out", valid_out, 0);
    chk("rst_last_out", last_out, 0);
    chk("rst_keep_out", keep_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_ready_in", ready_in, 0);
    chk("rst_ready_insert", ready_insert, 1);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_err_keep", err_keep, 0);
  endtask

  task automatic send_hdr(input int n, input logic [31:0] hdr, input logic [3:0] kins);
    bit ok = 0;
    valid_insert    = 1'b1;
    data_insert     = hdr;
    keep_insert     = kins;
    byte_insert_cnt = 3'(n);
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      ok = ready_insert;
      @(posedge clk);
      #1;
    end
    valid_insert = 1'b0;
    chk("hdr_handshake", ok, 1);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input bit l,
                           output int waits);
    bit ok = 0;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    waits    = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      ok = ready_in;
      if (!ok) waits++;
      @(posedge clk);
      #1;
    end
    chk("beat_handshake", ok, 1);
    chk("latency_valid_out", valid_out, 1);
  endtask

  task automatic send_pkt(input int n, input logic [31:0] hdr, input logic [31:0] dat[$],
                          input int lastcnt, input bit push, input bit gaps,
                          input bit bad_mid, input bit bad_hdr, input bit flushchk,
                          input bit nobubble, input bit rel);
    logic [3:0] kins, k, f;
    int         w;
    int         nb;
    nb = dat.size();
    f  = 4'hF;
    if (push) model_pkt(n, hdr, dat, lastcnt);
    kins = 4'((1 << n) - 1);
    if (bad_hdr) kins = kins ^ 4'b1000;
    send_hdr(n, hdr, kins);
    if (rel) bp_mode = 0;
    for (int j = 0; j < nb; j++) begin
      if (j == nb - 1) k = f << (4 - lastcnt);
      else             k = (bad_mid && j == 0) ? 4'b1100 : 4'hF;
      send_beat(dat[j], k, j == nb - 1, w);
      if (nobubble && j > 0) chk("no_bubble_wait", w, 0);
      if (gaps && j < nb - 1 && $urandom_range(0, 3) == 0) begin
        valid_in = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    valid_in = 1'b0;
    if (flushchk) chk("flush_ready_in", ready_in, 0);
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_q.size() != 0 || valid_out) && c < 5000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic rand_pkt(input int n, input bit gaps);
    logic [31:0] dat[$];
    int          nb;
    nb = $urandom_range(1, 5);
    for (int j = 0; j < nb; j++) dat.push_back($urandom);
    send_pkt(n, $urandom, dat, $urandom_range(1, 4), 1, gaps, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] dat[$];
    int          w;
    rst_n = 1'b0;
    valid_in = 0; data_in = '0; keep_in = '0; last_in = 0;
    valid_insert = 0; data_insert = '0; keep_insert = '0; byte_insert_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    dat = '{32'h11223344, 32'h55667788};
    send_pkt(2, 32'hAABBCCDD, dat, 2, 1, 0, 0, 0, 0, 1, 0);
    drain();
    chk("pkt_cnt_first", pkt_cnt, 16'(pkt_exp));

    dat = '{32'h01020304, 32'h05060708};
    send_pkt(3, 32'h00A1A2A3, dat, 3, 1, 0, 0, 0, 1, 1, 0);
    drain();

    rand_pkt(0, 0);
    rand_pkt(4, 0);
    dat = '{32'hC0C1C2C3, 32'hD0D1D2D3, 32'hE0E1E2E3};
    send_pkt(4, 32'h9A9B9C9D, dat, 1, 1, 0, 0, 0, 1, 1, 0);
    send_pkt(0, 32'h12345678, dat, 4, 1, 0, 0, 0, 0, 1, 0);
    drain();

    bp_mode = 2;
    @(posedge clk);
    #1;
    dat = '{32'h31323334};
    send_pkt(1, 32'h000000F1, dat, 2, 1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_last_stalled", valid_out & last_out & ~ready_out, 1);
    chk("b2b_ready_insert", ready_insert, 1);
    dat = '{32'h41424344, 32'h51525354};
    send_pkt(2, 32'h0000F2F3, dat, 4, 1, 0, 0, 0, 0, 0, 1);
    drain();
    chk("pkt_cnt_directed", pkt_cnt, 16'(pkt_exp));

    bp_mode = 1;
    for (int p = 0; p < 1000; p++) rand_pkt($urandom_range(0, 4), 1);
    drain();
    bp_mode = 0;
    chk("pkt_cnt_random", pkt_cnt, 16'(pkt_exp));
    chk("err_clean_traffic", err_keep, 0);

    dat = '{32'h61626364, 32'h71727374};
    send_pkt(1, 32'h000000AB, dat, 3, 1, 0, 1, 0, 0, 0, 0);
    drain();
    chk("err_mid_keep", err_keep, 1);
    rand_pkt(2, 0);
    drain();
    chk("err_sticky", err_keep, 1);

    send_hdr(2, 32'h0000BEEF, 4'b0011);
    send_beat(32'h81828384, 4'hF, 0, w);
    #2;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    #1;
    check_reset();
    exp_q.delete();
    pkt_exp = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rand_pkt(3, 0);
    drain();
    chk("pkt_cnt_after_reset", pkt_cnt, 16'(pkt_exp));
    chk("err_after_reset", err_keep, 0);

    dat = '{32'h91929394};
    send_pkt(2, 32'h0000CAFE, dat, 1, 1, 0, 0, 1, 0, 0, 0);
    drain();
    chk("err_hdr_keep", err_keep, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
